// File: rtl/pill_feeder.sv
// Pill dispense driver: paces the feed motor, emits one pill_pulse per pill,
// idles for a timed bottle swap on bottle_full and parks in DONE on finished.
module pill_feeder #(
   parameter int TICK_DIV   = 1000,
   parameter int SWAP_TICKS = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [3:0] speed,
   input  logic       bottle_full,
   input  logic       finished,
   output logic       pill_pulse,
   output logic       motor_on,
   output logic       swap_busy,
   output logic [1:0] state
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SWAP_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_FEED = 2'b01,
      S_SWAP = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q;
   logic [3:0]      gap_q, gap_d;
   logic [SW-1:0]   swap_q, swap_d;
   logic            pulse_q, pulse_d;
   logic            swap_busy_q;
   logic            tick;
   logic [3:0]      spd_c;
   logic [3:0]      gap_ld;
   logic            stall;

   // Free-running tick prescaler; never cleared by stop so pacing stays periodic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          pre_q <= '0;
      else if (pre_q == PW'(TICK_DIV - 1))   pre_q <= '0;
      else                                   pre_q <= pre_q + 1'b1;
   end

   assign tick   = (pre_q == PW'(TICK_DIV - 1));
   assign spd_c  = (speed > 4'd9) ? 4'd9 : speed;
   assign gap_ld = 4'd10 - spd_c;
   assign stall  = (speed == 4'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         gap_q       <= '0;
         swap_q      <= '0;
         pulse_q     <= 1'b0;
         swap_busy_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         swap_q      <= swap_d;
         pulse_q     <= pulse_d;
         swap_busy_q <= (state_d == S_SWAP);
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      swap_d  = swap_q;
      pulse_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FEED;
               gap_d   = gap_ld;
            end
         end
         S_FEED: begin
            if (bottle_full && pill_pulse) begin
               state_d = S_SWAP;
               swap_d  = SW'(SWAP_TICKS);
               gap_d   = '0;
            end else if (tick && !pause && !stall) begin
               // Reload samples speed here, so speed changes land at the next gap.
               if (gap_q <= 4'd1) begin
                  pulse_d = 1'b1;
                  gap_d   = gap_ld;
               end else begin
                  gap_d   = gap_q - 4'd1;
               end
            end
         end
         S_SWAP: begin
            if (!pause) begin
               if (swap_q == '0) begin
                  state_d = S_FEED;
                  gap_d   = gap_ld;
               end else if (tick) begin
                  swap_d  = swap_q - 1'b1;
               end
            end
         end
         S_DONE: begin
            if (!finished) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (finished && (state_q == S_FEED || state_q == S_SWAP)) begin
         state_d = S_DONE;
         gap_d   = '0;
         swap_d  = '0;
         pulse_d = 1'b0;
      end

      if (stop) begin
         state_d = S_IDLE;
         gap_d   = '0;
         swap_d  = '0;
         pulse_d = 1'b0;
      end
   end

   // finished masks a pulse already registered, so nothing escapes past the batch.
   assign pill_pulse = pulse_q & ~finished;
   assign motor_on   = (state_q == S_FEED) && !pause && !stall;
   assign swap_busy  = swap_busy_q;
   assign state      = state_q;

endmodule

// File: tb/tb_pill_feeder.sv
// Directed bench for pill_feeder: cycle-exact vector table from reset, then
// hand sequences for speed change, pause, finished, stop and reset corners.
module tb_pill_feeder;

   logic       clk;
   logic       reset_n;
   logic       start, stop, pause, bottle_full, finished;
   logic [3:0] speed;
   logic       pill_pulse, motor_on, swap_busy;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   pill_feeder #(.TICK_DIV(4), .SWAP_TICKS(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .speed       (speed),
      .bottle_full (bottle_full),
      .finished    (finished),
      .pill_pulse  (pill_pulse),
      .motor_on    (motor_on),
      .swap_busy   (swap_busy),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start, stop, pause;
      logic [3:0] speed;
      logic       bfull, fin;
      logic       e_pulse, e_motor, e_swap;
      logic [1:0] e_state;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic st, input logic bf, input logic ep, input logic em,
                    input logic es, input logic [1:0] est);
      vec_t x;
      x.start = st; x.stop = 1'b0; x.pause = 1'b0; x.speed = 4'd9;
      x.bfull = bf; x.fin = 1'b0;
      x.e_pulse = ep; x.e_motor = em; x.e_swap = es; x.e_state = est;
      vecs.push_back(x);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Advance until pill_pulse is seen; n = cycles taken, -1 on timeout.
   task automatic wait_pulse(input int max, output int n);
      int i;
      n = -1;
      i = 0;
      while (n < 0 && i < max) begin
         next_cyc();
         i++;
         if (pill_pulse) n = i;
      end
   endtask

   task automatic count_pulses(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         next_cyc();
         if (pill_pulse) cnt++;
      end
   endtask

   initial begin
      int n, cnt, ok;

      reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      speed = 4'd9; bottle_full = 1'b0; finished = 1'b0;

      // Cycle-exact table from reset release (prescaler phase 0 in cycle 0).
      v(0,0, 0,0,0,2'd0);                              // c0 reset state
      v(1,0, 0,0,0,2'd0);                              // c1 start
      v(0,0, 0,1,0,2'd1);                              // c2 FEED
      v(0,0, 0,1,0,2'd1);                              // c3 tick
      v(0,0, 1,1,0,2'd1);                              // c4 first pulse
      for (int i = 0; i < 3; i++) v(0,0, 0,1,0,2'd1);  // c5-7
      v(0,0, 1,1,0,2'd1);                              // c8
      for (int i = 0; i < 3; i++) v(0,0, 0,1,0,2'd1);  // c9-11
      v(0,1, 1,1,0,2'd1);                              // c12 pulse + bottle_full
      for (int i = 0; i < 12; i++) v(0,0, 0,0,1,2'd2); // c13-24 SWAP
      for (int i = 0; i < 3; i++) v(0,0, 0,1,0,2'd1);  // c25-27
      v(0,0, 1,1,0,2'd1);                              // c28
      v(0,0, 0,1,0,2'd1);                              // c29

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
         speed = vecs[i].speed; bottle_full = vecs[i].bfull; finished = vecs[i].fin;
         @(negedge clk);
         checks++;
         if (pill_pulse !== vecs[i].e_pulse || motor_on !== vecs[i].e_motor ||
             swap_busy !== vecs[i].e_swap || state !== vecs[i].e_state) begin
            failures++;
            $display("FAIL vec%0d actual p=%b m=%b s=%b st=%0d expected p=%b m=%b s=%b st=%0d",
                     i, pill_pulse, motor_on, swap_busy, state,
                     vecs[i].e_pulse, vecs[i].e_motor, vecs[i].e_swap, vecs[i].e_state);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0; bottle_full = 1'b0;
      @(negedge clk);

      // speed 7: 12-clk gaps; change to 9 mid-gap keeps current gap, then 4.
      stop = 1'b1; next_cyc(); stop = 1'b0;
      chk("stop_to_idle", state, 0);
      speed = 4'd7; start = 1'b1; next_cyc(); start = 1'b0;
      wait_pulse(20, n);
      chk("s7_first", (n >= 1 && n <= 13) ? 1 : 0, 1);
      wait_pulse(20, n);
      chk("s7_gap", n, 12);
      repeat (3) next_cyc();
      speed = 4'd9;
      wait_pulse(20, n);
      chk("s7_to_9_kept", n, 9);
      wait_pulse(10, n);
      chk("s9_after_change", n, 4);

      // Pause in FEED freezes the gap countdown (speed 7).
      speed = 4'd7;
      wait_pulse(10, n);
      chk("reload_s9", n, 4);
      chk("motor_feed", motor_on, 1);
      pause = 1'b1;
      #1 chk("motor_paused", motor_on, 0);
      count_pulses(20, cnt);
      chk("pause_no_pulses", cnt, 0);
      chk("pause_state", state, 1);
      pause = 1'b0;
      #1 chk("motor_unpaused", motor_on, 1);
      wait_pulse(20, n);
      chk("pause_frozen_gap", n, 12);

      // Pause in SWAP freezes the swap countdown.
      speed = 4'd9;
      wait_pulse(20, n);
      chk("s9_reload_after_pause", n, 12);
      bottle_full = 1'b1; next_cyc(); bottle_full = 1'b0;
      chk("swap_entered", state, 2);
      pause = 1'b1;
      count_pulses(20, cnt);
      chk("swap_pause_pulses", cnt, 0);
      chk("swap_pause_busy", swap_busy, 1);
      chk("swap_pause_motor", motor_on, 0);
      pause = 1'b0;
      n = 0;
      while (state == 2'd2 && n < 40) begin
         next_cyc();
         n++;
      end
      chk("swap_resume_cycles", n, 12);

      // Speed 0 stalls; speed 4'hC behaves as 9.
      stop = 1'b1; next_cyc(); stop = 1'b0;
      speed = 4'd0; start = 1'b1; next_cyc(); start = 1'b0;
      chk("stall_state", state, 1);
      chk("stall_motor", motor_on, 0);
      count_pulses(30, cnt);
      chk("stall_pulses", cnt, 0);
      stop = 1'b1; next_cyc(); stop = 1'b0;
      speed = 4'hC; start = 1'b1; next_cyc(); start = 1'b0;
      chk("spdC_motor", motor_on, 1);
      wait_pulse(6, n);
      ok = (n >= 1 && n <= 5) ? 1 : 0;
      chk("spdC_first", ok, 1);
      wait_pulse(10, n);
      chk("spdC_gap", n, 4);

      // finished in a pulse cycle masks the pulse; then DONE.
      finished = 1'b1;
      #1 chk("fin_masks_pulse", pill_pulse, 0);
      next_cyc();
      chk("fin_done", state, 3);
      finished = 1'b0; next_cyc();
      chk("done_to_idle", state, 0);

      // finished mid-gap: DONE, start ignored, no pulses ever after.
      speed = 4'd7; start = 1'b1; next_cyc(); start = 1'b0;
      wait_pulse(20, n);
      repeat (3) next_cyc();
      finished = 1'b1; next_cyc();
      chk("fin_mid_gap", state, 3);
      start = 1'b1; next_cyc(); start = 1'b0;
      count_pulses(30, cnt);
      chk("done_no_pulses", cnt, 0);
      chk("done_holds", state, 3);
      finished = 1'b0; next_cyc();
      chk("done_release", state, 0);

      // stop mid-SWAP, then clean restart.
      speed = 4'd9; start = 1'b1; next_cyc(); start = 1'b0;
      wait_pulse(10, n);
      bottle_full = 1'b1; next_cyc(); bottle_full = 1'b0;
      repeat (5) next_cyc();
      chk("pre_stop_swap", state, 2);
      stop = 1'b1; next_cyc(); stop = 1'b0;
      chk("stop_state", state, 0);
      chk("stop_swap_busy", swap_busy, 0);
      chk("stop_motor", motor_on, 0);
      chk("stop_pulse", pill_pulse, 0);
      start = 1'b1; next_cyc(); start = 1'b0;
      wait_pulse(6, n);
      ok = (n >= 1 && n <= 5) ? 1 : 0;
      chk("restart_first", ok, 1);
      wait_pulse(10, n);
      chk("restart_gap", n, 4);

      // Async reset mid-SWAP takes effect without a clock edge.
      bottle_full = 1'b1; next_cyc(); bottle_full = 1'b0;
      repeat (3) next_cyc();
      chk("pre_reset_swap", swap_busy, 1);
      reset_n = 1'b0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_swap_busy", swap_busy, 0);
      chk("rst_motor", motor_on, 0);
      chk("rst_pulse", pill_pulse, 0);
      next_cyc();
      reset_n = 1'b1;
      start = 1'b1; next_cyc(); start = 1'b0;
      chk("rst_restart_state", state, 1);
      wait_pulse(6, n);
      ok = (n >= 1 && n <= 5) ? 1 : 0;
      chk("rst_restart_first", ok, 1);
      wait_pulse(10, n);
      chk("rst_restart_gap", n, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
